// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: field widths, instruction field
// positions and the sequencer FSM state encoding.
package alu_pkg;

    parameter int OPC_W   = 4;
    parameter int DATA_W  = 8;
    parameter int INSTR_W = 20;

    // Instruction layout: [19:16] opcode, [15:8] operand A, [7:0] operand B
    parameter int OPC_MSB = 19;
    parameter int OPC_LSB = 16;
    parameter int A_MSB   = 15;
    parameter int A_LSB   = 8;
    parameter int B_MSB   = 7;
    parameter int B_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Instruction queue for the ALU sequencer.
// DEPTH-entry FIFO (DEPTH a power of two) with occupancy count.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, push_data write request and data (ignored when full)
//   pop, pop_data  read request (ignored when empty) and head-of-queue data
//   full, empty    status
//   count          occupancy, 0..DEPTH
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: queues instructions, feeds them one at a time to an external
// combinational ALU and registers each result behind a valid/ready handshake.
// Optional feature macro: ALU_SEQ_ACC_EN adds in_acc_sel; when set for an
// instruction, operand A is replaced by the last captured result.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_instr, in_valid/ready   instruction input {opcode, A, B} and handshake
//   in_acc_sel                 (ALU_SEQ_ACC_EN only) use accumulator as A
//   alu_opcode, alu_a, alu_b   operands to the ALU, from the operand register
//   alu_out, alu_carry/overflow/zero   ALU result and flags
//   res_data, res_carry/overflow/zero  registered result and flags
//   res_valid/res_ready        result handshake
//   busy                       FSM not idle or queue non-empty
//   q_count                    queue occupancy
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INSTR_W-1:0]            in_instr,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef ALU_SEQ_ACC_EN
    input  logic                          in_acc_sel,
`endif
    output logic [OPC_W-1:0]              alu_opcode,
    output logic [DATA_W-1:0]             alu_a,
    output logic [DATA_W-1:0]             alu_b,
    input  logic [DATA_W-1:0]             alu_out,
    input  logic                          alu_carry,
    input  logic                          alu_overflow,
    input  logic                          alu_zero,
    output logic [DATA_W-1:0]             res_data,
    output logic                          res_carry,
    output logic                          res_overflow,
    output logic                          res_zero,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   q_count
);

`ifdef ALU_SEQ_ACC_EN
    localparam int FIFO_W = INSTR_W + 1;
`else
    localparam int FIFO_W = INSTR_W;
`endif

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   opr_q, opr_d;
    logic [DATA_W-1:0]    res_data_q;
    logic                 res_carry_q, res_overflow_q, res_zero_q;
    logic                 res_valid_q;
    logic                 ready_en_q;

    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [FIFO_W-1:0]    fifo_wdata, fifo_rdata;
    logic [INSTR_W-1:0]   head_instr;
    logic                 capture, release_res;

`ifdef ALU_SEQ_ACC_EN
    logic head_acc_sel;
    assign fifo_wdata   = {in_acc_sel, in_instr};
    assign head_instr   = fifo_rdata[INSTR_W-1:0];
    assign head_acc_sel = fifo_rdata[INSTR_W];
`else
    assign fifo_wdata   = in_instr;
    assign head_instr   = fifo_rdata;
`endif

    // ready_en_q keeps in_ready low during reset and up to the first edge after.
    assign in_ready  = ready_en_q && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    alu_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (q_count)
    );

    // Operand register load value; the accumulator is simply the last result.
    always_comb begin
        opr_d = head_instr;
`ifdef ALU_SEQ_ACC_EN
        if (head_acc_sel) begin
            opr_d[A_MSB:A_LSB] = res_data_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                // res_valid is always high here, so res_ready completes the handshake.
                if (res_ready) begin
                    release_res = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = EXEC;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            opr_q          <= '0;
            res_data_q     <= '0;
            res_carry_q    <= 1'b0;
            res_overflow_q <= 1'b0;
            res_zero_q     <= 1'b0;
            res_valid_q    <= 1'b0;
            ready_en_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            if (fifo_pop) begin
                opr_q <= opr_d;
            end
            if (capture) begin
                res_data_q     <= alu_out;
                res_carry_q    <= alu_carry;
                res_overflow_q <= alu_overflow;
                res_zero_q     <= alu_zero;
                res_valid_q    <= 1'b1;
            end else if (release_res) begin
                res_valid_q    <= 1'b0;
            end
        end
    end

    assign alu_opcode   = opr_q[OPC_MSB:OPC_LSB];
    assign alu_a        = opr_q[A_MSB:A_LSB];
    assign alu_b        = opr_q[B_MSB:B_LSB];

    assign res_data     = res_data_q;
    assign res_carry    = res_carry_q;
    assign res_overflow = res_overflow_q;
    assign res_zero     = res_zero_q;
    assign res_valid    = res_valid_q;

    assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed steps, scoreboard of
// expected results, and an ALU model driving the DUT's ALU inputs.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [19:0] in_instr;
    logic        in_valid;
    logic        in_ready;
`ifdef ALU_SEQ_ACC_EN
    logic        in_acc_sel;
`endif
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic        alu_carry, alu_overflow, alu_zero;
    logic [7:0]  res_data;
    logic        res_carry, res_overflow, res_zero;
    logic        res_valid, res_ready;
    logic        busy;
    logic [2:0]  q_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_res = 0;
    logic [10:0] sb[$];
    logic [7:0]  last_exp = 8'h00;

    alu_sequencer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
`ifdef ALU_SEQ_ACC_EN
        .in_acc_sel   (in_acc_sel),
`endif
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .res_data     (res_data),
        .res_carry    (res_carry),
        .res_overflow (res_overflow),
        .res_zero     (res_zero),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .busy         (busy),
        .q_count      (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: add with carry, zero and signed overflow.
    logic [8:0] sum9;
    always_comb begin
        sum9         = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = sum9[7:0];
        alu_carry    = sum9[8];
        alu_zero     = (sum9[7:0] == 8'h00);
        alu_overflow = (alu_a[7] == alu_b[7]) && (sum9[7] != alu_a[7]);
    end

    // Expected {data, carry, overflow, zero}
    function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return {s[7:0], s[8], (a[7] == b[7]) && (s[7] != a[7]), s[7:0] == 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: compare every completed result handshake with the scoreboard.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            n_res++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL extra_result: observed result %0h expected none", res_data);
            end else begin
                check("result", {21'd0, res_data, res_carry, res_overflow, res_zero},
                      {21'd0, sb.pop_front()});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic sel);
        logic [7:0]  ea;
        logic [10:0] e;
        int k;
        in_instr = {op, a, b};
        in_valid = 1'b1;
`ifdef ALU_SEQ_ACC_EN
        in_acc_sel = sel;
        ea = sel ? last_exp : a;
`else
        ea = a;
        if (sel) $display("note: acc_sel ignored in this build");
`endif
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(ea, b);
        sb.push_back(e);
        last_exp = e[10:3];
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain", sb.size(), 32'd0);
    endtask

    int base;

    initial begin
        rst_n     = 1'b0;
        in_instr  = '0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
`ifdef ALU_SEQ_ACC_EN
        in_acc_sel = 1'b0;
`endif
        cycles(2);
        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_q_count", {29'd0, q_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res", {21'd0, res_data, res_carry, res_overflow, res_zero}, 32'd0);
        check("rst_operands", {12'd0, alu_opcode, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready_low", {31'd0, in_ready}, 32'd0);
        cycles(1);
        check("release_in_ready_high", {31'd0, in_ready}, 32'd1);

        // Single op latency: accepted on edge N, valid after N+2
        res_ready = 1'b1;
        send(4'h0, 8'h05, 8'h03, 1'b0);
        check("lat_n0_valid", {31'd0, res_valid}, 32'd0);
        cycles(1);
        check("lat_n1_valid", {31'd0, res_valid}, 32'd0);
        check("lat_n1_operands", {12'd0, alu_opcode, alu_a, alu_b}, 32'h00503);
        cycles(1);
        check("lat_n2_valid", {31'd0, res_valid}, 32'd1);
        check("lat_n2_data", {24'd0, res_data}, 32'h08);
        wait_drain();

        // Flags and throughput: queue three while stalled, then release
        res_ready = 1'b0;
        send(4'h1, 8'hFF, 8'h01, 1'b0);
        send(4'h2, 8'h7F, 8'h01, 1'b0);
        send(4'h3, 8'h80, 8'h80, 1'b0);
        check("hold_q_count", {29'd0, q_count}, 32'd2);
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_operands", {12'd0, alu_opcode, alu_a, alu_b}, 32'h1FF01);
        check("hold_flags_ff01", {21'd0, res_data, res_carry, res_overflow, res_zero},
              {21'd0, 8'h00, 1'b1, 1'b0, 1'b1});
        base = n_res;
        res_ready = 1'b1;
        cycles(1);
        check("tp_gap_valid", {31'd0, res_valid}, 32'd0);
        cycles(1);
        check("tp_second_valid", {31'd0, res_valid}, 32'd1);
        check("tp_flags_7f01", {21'd0, res_data, res_carry, res_overflow, res_zero},
              {21'd0, 8'h80, 1'b0, 1'b1, 1'b0});
        cycles(2);
        check("tp_count_4", n_res - base, 32'd2);
        cycles(1);
        check("tp_count_5", n_res - base, 32'd3);
        check("tp_busy_idle", {31'd0, busy}, 32'd0);

        // Back-pressure: five instructions with res_ready low
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(4'(i + 4), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
        end
        check("bp_q_count", {29'd0, q_count}, 32'd4);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        cycles(3);
        check("bp_hold_stable", {21'd0, res_data, res_carry, res_overflow, res_zero},
              {21'd0, sb[0]});
        check("bp_still_valid", {31'd0, res_valid}, 32'd1);
        res_ready = 1'b1;
        wait_drain();
        cycles(2);

        // Reset in HOLD with three queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'hA, 8'(8'h11 * i), 8'h22, 1'b0);
        end
        check("mid_q_count", {29'd0, q_count}, 32'd3);
        check("mid_valid", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_q_count", {29'd0, q_count}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_res", {21'd0, res_data, res_carry, res_overflow, res_zero}, 32'd0);
        sb.delete();
        last_exp = 8'h00;
        base = n_res;
        res_ready = 1'b1;
        cycles(1);
        rst_n = 1'b1;
        cycles(10);
        check("post_rst_no_result", n_res - base, 32'd0);
        check("post_rst_valid", {31'd0, res_valid}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef ALU_SEQ_ACC_EN
        // Accumulator chaining: 0x10+0x01, then acc+0x02
        send(4'h0, 8'h10, 8'h01, 1'b0);
        send(4'h0, 8'hAA, 8'h02, 1'b1);
        wait_drain();
`else
        send(4'h0, 8'h10, 8'h01, 1'b0);
        send(4'h0, 8'hAA, 8'h02, 1'b0);
        wait_drain();
`endif
        cycles(2);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_instr  input  20  instruction: [19:16] opcode, [15:8] operand A, [7:0] operand B.
REQ-006 in_valid / in_ready  input / output  1 / 1  instruction handshake; transfer when both high.
REQ-007 alu_opcode  output  4  opcode driven to the external combinational ALU.
REQ-008 alu_a, alu_b  output  8 each  operands driven to the ALU.
REQ-009 alu_out  input  8  ALU result.
REQ-010 alu_carry, alu_overflow, alu_zero  input  1 each  ALU flags.
REQ-011 res_data  output  8  registered ALU result.
REQ-012 res_carry, res_overflow, res_zero  output  1 each  registered flags.
REQ-013 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-014 busy  output  1  high when the FSM is not IDLE or the queue is non-empty.
REQ-015 q_count  output  $clog2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-016 The instruction queue SHALL be a FIFO_DEPTH-entry FIFO; in_ready = !full, with no bypass when full.
REQ-017 A push and a pop in the same cycle SHALL both occur, leaving q_count unchanged.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have three states: IDLE, EXEC and HOLD.
REQ-020 IDLE: if the queue is non-empty, pop the head into the operand register and go to EXEC; otherwise stay in IDLE.
REQ-021 EXEC: the ALU inputs are driven from the operand register for exactly one cycle.
REQ-022 EXEC exit: on that cycle's edge, capture alu_out and the flags into the res_* registers, set res_valid and go to HOLD.
REQ-023 HOLD: res_* SHALL be held stable while res_valid && !res_ready.
REQ-024 HOLD exit on a res_ready handshake with the queue non-empty: pop the next entry and go to EXEC, with res_valid deasserting for one cycle.
REQ-025 HOLD exit on a res_ready handshake with the queue empty: clear res_valid and go to IDLE.
REQ-026 Latency: an instruction accepted on edge N into an idle, empty block SHALL produce res_valid high after edge N+2.
REQ-027 Throughput with res_ready tied high SHALL be one result per 2 cycles.
REQ-028 alu_opcode, alu_a and alu_b SHALL be driven from the operand register in every state, and SHALL change only on a pop.
REQ-029 Results SHALL be delivered in strict acceptance order, with none dropped or duplicated.
REQ-030 All widths are fixed: 4-bit opcode, 8-bit data; the block performs no arithmetic of its own.

Reset
REQ-031 Asserting rst_n low SHALL immediately force state=IDLE, empty queue (pointers = 0), q_count=0, operand register=0, res_data=0, all res flags 0, res_valid=0 and busy=0.
REQ-032 While rst_n is low, in_ready SHALL be 0; it becomes 1 on the first edge after release.
REQ-033 A reset mid-operation SHALL discard queued and in-flight instructions, and no partial result SHALL appear after release.

Configuration
REQ-034 The macro ALU_SEQ_ACC_EN SHALL control accumulator chaining.
REQ-035 With ALU_SEQ_ACC_EN defined, the block SHALL add input port in_acc_sel (1 bit), queued alongside each instruction.
REQ-036 With ALU_SEQ_ACC_EN defined and in_acc_sel=1, operand A SHALL be taken from the last captured res_data instead of in_instr[15:8].
REQ-037 The accumulator SHALL reset to 0.
REQ-038 Without ALU_SEQ_ACC_EN, port in_acc_sel SHALL be absent, and A SHALL always come from the instruction.

Structure
REQ-039 Shared package alu_pkg SHALL hold: OPC_W=4, DATA_W=8, INSTR_W=20, the field bit positions, and the FSM state enum (IDLE, EXEC, HOLD).
REQ-040 The queue SHALL be a separate sub-module, alu_seq_fifo (parameterised depth and width, with count output), instantiated once.

Verification
REQ-041 The bench ALU model is out=A+B[7:0], carry=bit8, zero=(out==0), overflow=signed overflow.
REQ-042 Single op: opcode 0x0, A=0x05, B=0x03, res_ready=1 -> res_data=0x08, all flags 0, res_valid high after edge N+2.
REQ-043 Flags: A=0xFF, B=0x01 -> res_data=0x00, carry=1, zero=1; A=0x7F, B=0x01 -> res_data=0x80, overflow=1.
REQ-044 Back-pressure: push 5 instructions with res_ready=0 -> in_ready low after 4 queued (q_count=4, plus one held in HOLD); release res_ready -> 5 results in order.
REQ-045 Reset mid-run: assert rst_n low during HOLD with 3 queued -> res_valid=0 and q_count=0 immediately; no results after release.
REQ-046 ALU_SEQ_ACC_EN: op1 A=0x10, B=0x01; op2 in_acc_sel=1, B=0x02 -> results 0x11, then 0x13.
